// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I control unit:
// FSM state encodings, opcodes, ALU control codes and datapath select values.
package riscv_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_e;

  // Coarse ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Purely combinational ALU decoder: turns the FSM's ALU-op class plus the
// instruction's funct fields into the 3-bit ALU control code.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic       op_5,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  aluop_e     alu_op,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // funct7[5] only means sub for R-type; for I-type that bit is immediate
          3'b000:  alu_control = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the multicycle RV32I core (lw, sw, R, I, beq, jal).
// Define MULTICYCLE_CTRL_ILLEGAL_EN to trap unsupported opcodes and expose ILLEGAL.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] OP,
  input  logic [2:0] FUNCT3,
  input  logic       FUNCT7_5,
  input  logic       ZERO,
  input  logic       MEM_READY,
  output logic       MEM_REQ,
  output logic       MEM_WR,
  output logic       ADR_SRC,
  output logic       IR_WRITE,
  output logic       PC_WRITE,
  output logic       REG_WRITE,
  output logic [1:0] RESULT_SRC,
  output logic [1:0] ALU_SRC_A,
  output logic [1:0] ALU_SRC_B,
  output logic [2:0] ALU_CONTROL,
  output logic [1:0] IMM_SRC,
  output logic [3:0] STATE
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
  ,
  output logic       ILLEGAL
`endif
);

  state_e     state_q, state_d;
  aluop_e     alu_op;
  logic [2:0] alu_control;
  logic [1:0] imm_src;
  logic       mem_req, mem_wr, adr_src, ir_write, pc_write, reg_write;
  logic [1:0] result_src, src_a, src_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (MEM_READY) state_d = S_DECODE;
      S_DECODE: begin
        case (OP)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
          default:      state_d = S_TRAP;
`else
          default:      state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR:   state_d = OP[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (MEM_READY) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (MEM_READY) state_d = S_FETCH;
      S_EXECR,
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_wr     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_REG;
    alu_op     = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = MEM_READY;
        pc_write   = MEM_READY;
      end
      S_DECODE: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a = SRCA_REG;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_wr  = 1'b1;
        adr_src = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_REG;
        alu_op = ALUOP_FUNCT;
      end
      S_EXECI: begin
        src_a  = SRCA_REG;
        src_b  = SRCB_IMM;
        alu_op = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        src_a    = SRCA_REG;
        alu_op   = ALUOP_SUB;
        pc_write = ZERO;
      end
      S_JAL: begin
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (OP)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
      default: imm_src = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .op_5        (OP[5]),
    .funct3      (FUNCT3),
    .funct7_5    (FUNCT7_5),
    .alu_op      (alu_op),
    .alu_control (alu_control)
  );

  // Reset must silence every strobe and select immediately, even mid-instruction
  assign MEM_REQ     = RST_N & mem_req;
  assign MEM_WR      = RST_N & mem_wr;
  assign ADR_SRC     = RST_N & adr_src;
  assign IR_WRITE    = RST_N & ir_write;
  assign PC_WRITE    = RST_N & pc_write;
  assign REG_WRITE   = RST_N & reg_write;
  assign RESULT_SRC  = RST_N ? result_src  : 2'b00;
  assign ALU_SRC_A   = RST_N ? src_a       : 2'b00;
  assign ALU_SRC_B   = RST_N ? src_b       : 2'b00;
  assign ALU_CONTROL = RST_N ? alu_control : 3'b000;
  assign IMM_SRC     = RST_N ? imm_src     : 2'b00;
  assign STATE       = state_q;

`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
  logic illegal_q, illegal_d;

  always_comb illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) illegal_q <= 1'b0;
    else        illegal_q <= illegal_d;
  end

  assign ILLEGAL = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them.
module tb_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [6:0] OP;
  logic [2:0] FUNCT3;
  logic       FUNCT7_5;
  logic       ZERO;
  logic       MEM_READY;
  logic       MEM_REQ, MEM_WR, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE;
  logic [1:0] RESULT_SRC, ALU_SRC_A, ALU_SRC_B, IMM_SRC;
  logic [2:0] ALU_CONTROL;
  logic [3:0] STATE;
  logic       illegal;

  typedef logic [21:0] vec_t;

  vec_t  expQ[$];
  string nameQ[$];
  string curName = "reset";
  int    compared = 0;
  int    mismatched = 0;

  multicycle_ctrl dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .OP          (OP),
    .FUNCT3      (FUNCT3),
    .FUNCT7_5    (FUNCT7_5),
    .ZERO        (ZERO),
    .MEM_READY   (MEM_READY),
    .MEM_REQ     (MEM_REQ),
    .MEM_WR      (MEM_WR),
    .ADR_SRC     (ADR_SRC),
    .IR_WRITE    (IR_WRITE),
    .PC_WRITE    (PC_WRITE),
    .REG_WRITE   (REG_WRITE),
    .RESULT_SRC  (RESULT_SRC),
    .ALU_SRC_A   (ALU_SRC_A),
    .ALU_SRC_B   (ALU_SRC_B),
    .ALU_CONTROL (ALU_CONTROL),
    .IMM_SRC     (IMM_SRC),
    .STATE       (STATE)
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
    ,
    .ILLEGAL     (illegal)
`endif
  );

`ifndef MULTICYCLE_CTRL_ILLEGAL_EN
  assign illegal = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Field order: illegal, state, {req,wr,adr,irw,pcw,rw}, result, srcA, srcB, alu, imm
  function automatic vec_t mk(input logic [3:0] st, input logic [5:0] strobes,
                              input logic [1:0] rs, input logic [1:0] sa,
                              input logic [1:0] sb, input logic [2:0] alu,
                              input logic [1:0] imm, input logic ill);
    return {ill, st, strobes, rs, sa, sb, alu, imm};
  endfunction

  function automatic vec_t fetchV(input logic rdy, input logic [1:0] imm);
    return mk(4'd0, {3'b100, rdy, rdy, 1'b0}, 2'b10, 2'b00, 2'b10, 3'b000, imm, 1'b0);
  endfunction

  function automatic vec_t decodeV(input logic [1:0] imm);
    return mk(4'd1, 6'b000000, 2'b00, 2'b01, 2'b01, 3'b000, imm, 1'b0);
  endfunction

  function automatic vec_t resetV();
    return mk(4'd0, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0);
  endfunction

  task automatic setInstr(input string name, input logic [6:0] op,
                          input logic [2:0] f3, input logic f75);
    curName  = name;
    OP       = op;
    FUNCT3   = f3;
    FUNCT7_5 = f75;
  endtask

  task automatic applyStimulus(input logic rst, input logic rdy, input logic zero,
                               input vec_t e);
    RST_N     = rst;
    MEM_READY = rdy;
    ZERO      = zero;
    expQ.push_back(e);
    nameQ.push_back(curName);
    @(posedge CLK);
    #1;
  endtask

  // Four-cycle ALU instruction: FETCH, DECODE, EXECR/EXECI, ALUWB
  task automatic aluInstr(input string name, input logic [6:0] op, input logic [2:0] f3,
                          input logic f75, input logic [3:0] execSt,
                          input logic [1:0] srcB, input logic [2:0] expAlu);
    setInstr(name, op, f3, f75);
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, decodeV(2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(execSt, 6'b000000, 2'b00, 2'b10, srcB, expAlu, 2'b00, 1'b0));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
  endtask

  task automatic checkOutput(input vec_t act, input vec_t e, input string name);
    compared++;
    if (act !== e) begin
      mismatched++;
      $display("[TB] FAIL %s: got ill/st/strb/rs/sa/sb/alu/imm=%b/%0d/%b/%b/%b/%b/%b/%b expected %b/%0d/%b/%b/%b/%b/%b/%b",
               name, act[21], act[20:17], act[16:11], act[10:9], act[8:7], act[6:5], act[4:2], act[1:0],
               e[21], e[20:17], e[16:11], e[10:9], e[8:7], e[6:5], e[4:2], e[1:0]);
    end
  endtask

  always @(negedge CLK) begin
    if (expQ.size() > 0) begin
      vec_t  e;
      string n;
      e = expQ.pop_front();
      n = nameQ.pop_front();
      checkOutput({illegal, STATE, MEM_REQ, MEM_WR, ADR_SRC, IR_WRITE, PC_WRITE, REG_WRITE,
                   RESULT_SRC, ALU_SRC_A, ALU_SRC_B, ALU_CONTROL, IMM_SRC}, e, n);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST_N = 1'b0;
    MEM_READY = 1'b1;
    ZERO = 1'b1;
    setInstr("reset", 7'b1101111, 3'b000, 1'b0);
    @(posedge CLK);
    #1;
    // jal opcode and ZERO high during reset: selects and strobes must still be 0
    applyStimulus(1'b0, 1'b1, 1'b1, resetV());
    applyStimulus(1'b0, 1'b1, 1'b1, resetV());

    aluInstr("add",  7'b0110011, 3'b000, 1'b0, 4'd6, 2'b00, 3'b000);
    aluInstr("sub",  7'b0110011, 3'b000, 1'b1, 4'd6, 2'b00, 3'b001);
    aluInstr("slt",  7'b0110011, 3'b010, 1'b0, 4'd6, 2'b00, 3'b101);
    aluInstr("and",  7'b0110011, 3'b111, 1'b0, 4'd6, 2'b00, 3'b010);
    aluInstr("sll",  7'b0110011, 3'b001, 1'b1, 4'd6, 2'b00, 3'b000);
    aluInstr("ori",  7'b0010011, 3'b110, 1'b1, 4'd7, 2'b01, 3'b011);
    aluInstr("addi", 7'b0010011, 3'b000, 1'b1, 4'd7, 2'b01, 3'b000);

    setInstr("lw", 7'b0000011, 3'b010, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, fetchV(1'b0, 2'b00));
    applyStimulus(1'b1, 1'b0, 1'b0, fetchV(1'b0, 2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, decodeV(2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, mk(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd4, 6'b000001, 2'b01, 2'b00, 2'b00, 3'b000, 2'b00, 1'b0));

    setInstr("beq_taken", 7'b1100011, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, fetchV(1'b1, 2'b10));
    applyStimulus(1'b1, 1'b1, 1'b1, decodeV(2'b10));
    applyStimulus(1'b1, 1'b1, 1'b1, mk(4'd9, 6'b000010, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0));

    setInstr("beq_not_taken", 7'b1100011, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b10));
    applyStimulus(1'b1, 1'b1, 1'b1, decodeV(2'b10));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd9, 6'b000000, 2'b00, 2'b10, 2'b00, 3'b001, 2'b10, 1'b0));

    // MEM_READY low in DECODE/MEMADR must not stall them
    setInstr("sw", 7'b0100011, 3'b010, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b01));
    applyStimulus(1'b1, 1'b0, 1'b0, decodeV(2'b01));
    applyStimulus(1'b1, 1'b0, 1'b0, mk(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0));

    setInstr("jal", 7'b1101111, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b11));
    applyStimulus(1'b1, 1'b1, 1'b0, decodeV(2'b11));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd10, 6'b000010, 2'b00, 2'b01, 2'b10, 3'b000, 2'b11, 1'b0));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd8, 6'b000001, 2'b00, 2'b00, 2'b00, 3'b000, 2'b11, 1'b0));

    setInstr("sw_reset_abort", 7'b0100011, 3'b010, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b01));
    applyStimulus(1'b1, 1'b1, 1'b0, decodeV(2'b01));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd2, 6'b000000, 2'b00, 2'b10, 2'b01, 3'b000, 2'b01, 1'b0));
    applyStimulus(1'b1, 1'b0, 1'b0, mk(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 1'b0));
    applyStimulus(1'b0, 1'b0, 1'b0, resetV());

    setInstr("illegal", 7'b1111111, 3'b000, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, decodeV(2'b00));
`ifdef MULTICYCLE_CTRL_ILLEGAL_EN
    applyStimulus(1'b1, 1'b1, 1'b1, mk(4'd11, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
    applyStimulus(1'b1, 1'b0, 1'b1, mk(4'd11, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
    applyStimulus(1'b1, 1'b1, 1'b0, mk(4'd11, 6'b000000, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 1'b1));
    applyStimulus(1'b0, 1'b1, 1'b0, resetV());
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b00));
`else
    applyStimulus(1'b1, 1'b1, 1'b0, fetchV(1'b1, 2'b00));
    applyStimulus(1'b1, 1'b1, 1'b0, decodeV(2'b00));
`endif

    // Bounded drain: every pushed expectation must have been consumed by the monitor
    for (int i = 0; i < 4 && expQ.size() > 0; i++) @(posedge CLK);
    compared++;
    if (expQ.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main control unit for the multicycle variant of the RV32I core. It sequences one shared instruction/data memory, the register file, the ALU and the PC register over several cycles per instruction. It is a Moore FSM with memory-ready qualified strobes, and sits between the instruction register and the datapath mux and enable inputs. It supports lw, sw, R-type, I-type ALU, beq and jal.

## Interface
Parameters: none.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- OP  in  7  instruction opcode, INSTR[6:0] from the instruction register.
- FUNCT3  in  3  INSTR[14:12].
- FUNCT7_5  in  1  INSTR[30].
- ZERO  in  1  ALU zero flag.
- MEM_READY  in  1  memory completes the current access this cycle.
- MEM_REQ  out  1  memory access request.
- MEM_WR  out  1  memory write enable; only asserted together with MEM_REQ.
- ADR_SRC  out  1  memory address select: 0 = PC, 1 = ALU_OUT register.
- IR_WRITE  out  1  load the instruction register and OLD_PC.
- PC_WRITE  out  1  PC register enable.
- REG_WRITE  out  1  register file write enable.
- RESULT_SRC  out  2  result select: 00 = ALU_OUT, 01 = DATA register, 10 = ALU_RESULT.
- ALU_SRC_A  out  2  ALU A select: 00 = PC, 01 = OLD_PC, 10 = A register.
- ALU_SRC_B  out  2  ALU B select: 00 = WD register, 01 = IMM_EXT, 10 = constant 4.
- ALU_CONTROL  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt.
- IMM_SRC  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
- STATE  out  4  current state encoding, for debug.
- ILLEGAL  out  1  sticky illegal-opcode flag; only present with the macro.

## Operation
- State encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4, MEMWRITE = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BEQ = 9, JAL = 10, TRAP = 11.
- FETCH
  - Outputs: MEM_REQ = 1, ADR_SRC = 0, ALU computes PC + 4 (SRC_A = 00, SRC_B = 10, add), RESULT_SRC = 10.
  - IR_WRITE = MEM_READY and PC_WRITE = MEM_READY.
  - Stays in FETCH while MEM_READY = 0; goes to DECODE when MEM_READY = 1.
- DECODE
  - Outputs: SRC_A = 01, SRC_B = 01, add. This precomputes the branch target.
  - Next state from OP:
    - 0000011 (lw) and 0100011 (sw) go to MEMADR.
    - 0110011 (R-type) goes to EXECR.
    - 0010011 (I-type) goes to EXECI.
    - 1100011 (beq) goes to BEQ.
    - 1101111 (jal) goes to JAL.
    - Any other opcode: see Configuration.
- MEMADR
  - Outputs: SRC_A = 10, SRC_B = 01, add.
  - Goes to MEMREAD if OP[5] = 0, otherwise MEMWRITE.
- MEMREAD: MEM_REQ = 1, ADR_SRC = 1. Waits for MEM_READY, then goes to MEMWB.
- MEMWB: RESULT_SRC = 01, REG_WRITE = 1, then goes to FETCH.
- MEMWRITE: MEM_REQ = 1, MEM_WR = 1, ADR_SRC = 1. Waits for MEM_READY, then goes to FETCH.
- EXECR: SRC_A = 10, SRC_B = 00, ALU operation decoded, then goes to ALUWB.
- EXECI: SRC_A = 10, SRC_B = 01, ALU operation decoded, then goes to ALUWB.
- ALUWB: RESULT_SRC = 00, REG_WRITE = 1, then goes to FETCH.
- BEQ
  - Outputs: SRC_A = 10, SRC_B = 00, sub, RESULT_SRC = 00.
  - PC_WRITE = ZERO, then goes to FETCH.
- JAL
  - Outputs: SRC_A = 01, SRC_B = 10, add, RESULT_SRC = 00, PC_WRITE = 1.
  - Then goes to ALUWB.
- ALU decode in EXECR and EXECI:
  - FUNCT3 000 gives sub if OP[5] = 1 and FUNCT7_5 = 1, otherwise add.
  - FUNCT3 010 gives slt, 110 gives or, 111 gives and.
  - Any other FUNCT3 gives add.
- IMM_SRC is combinational from OP in every state:
  - lw and I-type give 00, sw gives 01, beq gives 10, jal gives 11.
  - Any other opcode gives 00.
- Output defaults: every output not listed for the current state is 0.

## Timing
- Reset
  - While RST_N = 0: STATE = FETCH and every strobe (MEM_REQ, MEM_WR, IR_WRITE, PC_WRITE, REG_WRITE) is forced to 0.
  - All mux selects are forced to 0, and ILLEGAL = 0.
  - Reset asserted mid-instruction aborts it immediately; no write strobe is asserted in that cycle.
  - The first fetch request is issued in the first cycle after RST_N rises.
- Latency with zero-wait memory:
  - beq: 3 cycles.
  - R-type, I-type, sw and jal: 4 cycles.
  - lw: 5 cycles.
  - Each cycle with MEM_READY = 0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Handshake
  - MEM_REQ, MEM_WR and ADR_SRC are held stable until the cycle in which MEM_READY = 1.
  - MEM_READY is ignored in every other state.
- ZERO is sampled only in BEQ.
- All outputs are combinational from STATE, except these Mealy terms:
  - IR_WRITE and PC_WRITE in FETCH are qualified by MEM_READY.
  - PC_WRITE in BEQ is qualified by ZERO.
  - IMM_SRC and ALU_CONTROL also depend on the OP, FUNCT3 and FUNCT7_5 inputs.

## Configuration
- Macro: MULTICYCLE_CTRL_ILLEGAL_EN.
- With the macro defined:
  - An unsupported opcode in DECODE goes to TRAP.
  - TRAP holds all strobes at 0 until reset.
  - ILLEGAL is set on entry to TRAP and stays at 1 until reset.
- Without the macro:
  - An unsupported opcode in DECODE returns to FETCH, so the instruction executes as a nop.
  - The TRAP state and the ILLEGAL port do not exist.

## Structure
- Package riscv_pkg holds:
  - the state enum;
  - the opcode constants OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL;
  - the ALU_CONTROL codes;
  - the RESULT_SRC, ALU_SRC_A, ALU_SRC_B and IMM_SRC select constants.
- Sub-module alu_decoder (purely combinational) maps OP[5], FUNCT3, FUNCT7_5 and an "ALU-op" class to ALU_CONTROL.
- The FSM, the output decode and IMM_SRC decode remain in multicycle_ctrl.

## Test plan
- add x3,x1,x2 (OP = 0110011, FUNCT3 = 000, FUNCT7_5 = 0), MEM_READY = 1 throughout -> STATE sequence 0, 1, 6, 8, 0; ALU_CONTROL = 000 in EXECR; REG_WRITE = 1 only in ALUWB.
- lw with MEM_READY held low for 2 cycles in FETCH and 1 cycle in MEMREAD -> 8 cycles total; MEM_REQ and ADR_SRC stable while waiting; IR_WRITE pulses once.
- beq with ZERO = 1, then with ZERO = 0 -> PC_WRITE = 1 in the BEQ cycle only in the first case; ALU_CONTROL = 001 in both.
- sw -> STATE sequence 0, 1, 2, 5, 0; MEM_WR = 1 only in MEMWRITE; IMM_SRC = 01.
- jal -> STATE sequence 0, 1, 10, 8, 0; PC_WRITE = 1 in JAL; REG_WRITE = 1 in ALUWB; IMM_SRC = 11.
- OP = 1111111, and separately RST_N dropped during MEMWRITE:
  - With the macro, the illegal opcode goes to TRAP with ILLEGAL = 1 held; without it, STATE returns to FETCH.
  - The reset drop gives MEM_WR = 0 at once and STATE = 0.
